// File: rtl/nubus_slave_resp.sv
// rtl/nubus_slave_resp.sv - NuBus slave responder turning a bus cycle into one local memory request
//
// Purpose:
//   Watches START on NuBus. When the address falls in this card's standard
//   slot space, the cycle is converted into a single request on the local
//   memory bus. When that request completes, or times out, the responder
//   drives ACK with a status code and, for reads, drives the data onto AD.
//
// Ports:
//   mem_clk, mem_reset      clock (rising edge = NuBus sampling edge), sync active-high reset
//   nub_idn                 slot ID pins, active low
//   nub_startn              START, active low
//   nub_tm1n_i, nub_tm0n_i  transfer mode from bus, active low
//   nub_adn_i               AD from bus, active low
//   nub_adn_o, nub_ad_oe    AD drive value (active low) and its enable
//   nub_tmn_o, nub_tm_oe    status drive {TM1n,TM0n} and its enable
//   nub_ackn_o, nub_ack_oe  ACK drive (active low) and its enable
//   mem_valid, mem_ready    local request / one-cycle completion pulse
//   mem_wstrb               byte strobes, 4'b0000 means read
//   mem_addr, mem_wdata     word-aligned address and write data
//   mem_rdata               read data, valid with mem_ready
//   mem_myslot, mem_myexp   request targets standard slot / super-slot space
//
// Build option:
//   NUBUS_SLAVE_SUPERSLOT_EN  when defined, the card also answers in its
//   super-slot space (ad[31:28] == slot ID, ID 1..E) and flags such requests
//   on mem_myexp. When undefined, mem_myexp is always 0.

module nubus_slave_resp #(
  parameter int         TIMEOUT_CYCLES = 200,
  parameter logic [3:0] SLOT_HI        = 4'hF
) (
  input  logic        mem_clk,
  input  logic        mem_reset,
  input  logic [3:0]  nub_idn,
  input  logic        nub_startn,
  input  logic        nub_tm0n_i,
  input  logic        nub_tm1n_i,
  input  logic [31:0] nub_adn_i,
  output logic [31:0] nub_adn_o,
  output logic        nub_ad_oe,
  output logic [1:0]  nub_tmn_o,
  output logic        nub_tm_oe,
  output logic        nub_ackn_o,
  output logic        nub_ack_oe,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_myslot,
  output logic        mem_myexp
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, MEM, ACK} state_t;

  state_t state, state_nxt;

  // Bus pins are active low; work with true-polarity copies internally.
  logic [31:0] ad;
  logic [1:0]  tm;
  logic [3:0]  slot_id;

  assign ad      = ~nub_adn_i;
  assign tm      = ~{nub_tm1n_i, nub_tm0n_i};
  assign slot_id = ~nub_idn;

  logic slot_hit, exp_hit, hit;

  assign slot_hit = ~nub_startn && (ad[31:24] == {SLOT_HI, slot_id});

`ifdef NUBUS_SLAVE_SUPERSLOT_EN
  // IDs 0 and F have no super-slot space.
  assign exp_hit = ~nub_startn && (ad[31:28] == slot_id) &&
                   (slot_id != 4'h0) && (slot_id != 4'hF);
`else
  assign exp_hit = 1'b0;
`endif

  assign hit = slot_hit | exp_hit;

  // Cycle state captured at START and across the memory phase.
  logic [31:2]      addr_q;
  logic [1:0]       mode_q;
  logic [1:0]       tm_q;
  logic             is_exp;
  logic [1:0]       status_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt;

  logic mem_done, mem_tout;

  // cnt counts the cycles mem_valid has been high. Timing out at
  // TIMEOUT_CYCLES-1 makes the error ACK appear exactly TIMEOUT_CYCLES cycles
  // after mem_valid rose, because ACK is registered one cycle after the
  // MEM->ACK decision. mem_ready always wins over the timeout.
  assign mem_done = (state == MEM) && mem_ready;
  assign mem_tout = (state == MEM) && !mem_ready &&
                    (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-cycle values of the registered outputs.
  logic        mem_valid_d, myslot_d, myexp_d;
  logic [3:0]  mem_wstrb_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic        ad_oe_d, tm_oe_d, ack_oe_d, ackn_d;
  logic [1:0]  tmn_d;
  logic [31:0] adn_d;

  function automatic logic [3:0] write_strobe(input logic tm0, input logic [1:0] lane);
    logic [3:0] s;
    if (tm0) begin
      s = 4'b0001 << lane;
    end else begin
      case (lane)
        2'b10:   s = 4'b0011;
        2'b11:   s = 4'b1100;
        default: s = 4'b1111;   // word, or block treated as a single beat
      endcase
    end
    return s;
  endfunction

  // State register
  always_ff @(posedge mem_clk) begin
    if (mem_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = DATA;
      DATA:    state_nxt = MEM;
      MEM:     if (mem_done || mem_tout) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: computes the values the output registers take next edge.
  always_comb begin
    logic keep;
    keep        = 1'b0;
    mem_valid_d = 1'b0;
    myslot_d    = 1'b0;
    myexp_d     = 1'b0;
    mem_wstrb_d = mem_wstrb;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    ad_oe_d     = 1'b0;
    adn_d       = '1;
    tm_oe_d     = 1'b0;
    tmn_d       = 2'b11;
    ack_oe_d    = 1'b0;
    ackn_d      = 1'b1;
    case (state)
      DATA: begin
        // The master drives write data on AD the cycle after START.
        mem_valid_d = 1'b1;
        myslot_d    = ~is_exp;
        myexp_d     = is_exp;
        mem_addr_d  = {addr_q, 2'b00};
        mem_wdata_d = tm_q[1] ? ad : '0;
        mem_wstrb_d = tm_q[1] ? write_strobe(tm_q[0], mode_q) : 4'b0000;
      end
      MEM: begin
        keep        = !(mem_done || mem_tout);
        mem_valid_d = keep;
        myslot_d    = keep & ~is_exp;
        myexp_d     = keep & is_exp;
      end
      ACK: begin
        ack_oe_d = 1'b1;
        ackn_d   = 1'b0;
        tm_oe_d  = 1'b1;
        tmn_d    = ~status_q;
        if (!tm_q[1]) begin
          ad_oe_d = 1'b1;
          adn_d   = ~rdata_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge mem_clk) begin
    if (mem_reset) begin
      addr_q     <= '0;
      mode_q     <= '0;
      tm_q       <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
      mem_valid  <= 1'b0;
      mem_myslot <= 1'b0;
      mem_myexp  <= 1'b0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      nub_ad_oe  <= 1'b0;
      nub_adn_o  <= '1;
      nub_tm_oe  <= 1'b0;
      nub_tmn_o  <= 2'b11;
      nub_ack_oe <= 1'b0;
      nub_ackn_o <= 1'b1;
    end else begin
      if (state == IDLE && hit) begin
        addr_q <= ad[31:2];
        mode_q <= ad[1:0];
        tm_q   <= tm;
      end

      if (state == DATA) begin
        cnt <= CNT_W'(1);
      end else if (state == MEM && !mem_done && !mem_tout) begin
        cnt <= cnt + 1'b1;
      end

      if (mem_done) begin
        status_q <= 2'b00;
        if (!tm_q[1]) rdata_q <= mem_rdata;
      end else if (mem_tout) begin
        status_q <= 2'b01;
        rdata_q  <= '0;
      end

      mem_valid  <= mem_valid_d;
      mem_myslot <= myslot_d;
      mem_myexp  <= myexp_d;
      mem_wstrb  <= mem_wstrb_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      nub_ad_oe  <= ad_oe_d;
      nub_adn_o  <= adn_d;
      nub_tm_oe  <= tm_oe_d;
      nub_tmn_o  <= tmn_d;
      nub_ack_oe <= ack_oe_d;
      nub_ackn_o <= ackn_d;
    end
  end

`ifdef NUBUS_SLAVE_SUPERSLOT_EN
  always_ff @(posedge mem_clk) begin
    if (mem_reset) begin
      is_exp <= 1'b0;
    end else if (state == IDLE && hit) begin
      is_exp <= exp_hit;
    end
  end
`else
  assign is_exp = 1'b0;
`endif

endmodule

// File: tb/tb_nubus_slave_resp.sv
// tb/tb_nubus_slave_resp.sv - directed self-checking bench for nubus_slave_resp

module tb_nubus_slave_resp;

  logic        mem_clk;
  logic        mem_reset;
  logic [3:0]  nub_idn;
  logic        nub_startn;
  logic        nub_tm0n_i;
  logic        nub_tm1n_i;
  logic [31:0] nub_adn_i;
  logic [31:0] nub_adn_o;
  logic        nub_ad_oe;
  logic [1:0]  nub_tmn_o;
  logic        nub_tm_oe;
  logic        nub_ackn_o;
  logic        nub_ack_oe;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_myslot;
  logic        mem_myexp;

  int n_checks = 0;
  int n_fail   = 0;

  nubus_slave_resp dut (
    .mem_clk    (mem_clk),
    .mem_reset  (mem_reset),
    .nub_idn    (nub_idn),
    .nub_startn (nub_startn),
    .nub_tm0n_i (nub_tm0n_i),
    .nub_tm1n_i (nub_tm1n_i),
    .nub_adn_i  (nub_adn_i),
    .nub_adn_o  (nub_adn_o),
    .nub_ad_oe  (nub_ad_oe),
    .nub_tmn_o  (nub_tmn_o),
    .nub_tm_oe  (nub_tm_oe),
    .nub_ackn_o (nub_ackn_o),
    .nub_ack_oe (nub_ack_oe),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_myslot (mem_myslot),
    .mem_myexp  (mem_myexp)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge mem_clk);
    #1;
  endtask

  // Address phase then data phase; returns just after the edge where
  // mem_valid should first be visible.
  task automatic start_cycle(input logic [31:0] bus_ad, input logic [1:0] tmv,
                             input logic [31:0] wdata);
    nub_startn = 1'b0;
    nub_adn_i  = ~bus_ad;
    nub_tm1n_i = ~tmv[1];
    nub_tm0n_i = ~tmv[0];
    tick;
    nub_startn = 1'b1;
    nub_tm1n_i = 1'b1;
    nub_tm0n_i = 1'b1;
    nub_adn_i  = tmv[1] ? ~wdata : 32'hFFFF_FFFF;
    tick;
    nub_adn_i  = 32'hFFFF_FFFF;
  endtask

  task automatic xfer(input string tag, input logic [31:0] bus_ad, input logic [1:0] tmv,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                      input int wait_cyc);
    start_cycle(bus_ad, tmv, wdata);
    check({tag, "_valid"},  mem_valid, 1);
    check({tag, "_addr"},   mem_addr, exp_addr);
    check({tag, "_strb"},   mem_wstrb, exp_strb);
    check({tag, "_wdata"},  mem_wdata, tmv[1] ? wdata : 32'h0);
    check({tag, "_myslot"}, mem_myslot, 1);
    check({tag, "_myexp"},  mem_myexp, 0);
    repeat (wait_cyc) tick;
    check({tag, "_hold"},   {mem_valid, mem_wstrb, mem_addr[7:0]}, {1'b1, exp_strb, exp_addr[7:0]});
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    check({tag, "_vdrop"},  mem_valid, 0);
    check({tag, "_noack"},  nub_ack_oe, 0);
    tick;
    check({tag, "_ack"},    {nub_ack_oe, nub_ackn_o, nub_tm_oe, nub_tmn_o}, {1'b1, 1'b0, 1'b1, 2'b11});
    check({tag, "_adoe"},   nub_ad_oe, !tmv[1]);
    if (!tmv[1]) check({tag, "_rdata"}, ~nub_adn_o, rdata);
    tick;
    check({tag, "_ackend"}, {nub_ack_oe, nub_tm_oe, nub_ad_oe, nub_ackn_o}, 4'b0001);
  endtask

  initial begin
    logic seen;
    int   k;
    mem_reset  = 1'b1;
    nub_idn    = 4'hF;          // slot ID 0
    nub_startn = 1'b1;
    nub_tm0n_i = 1'b1;
    nub_tm1n_i = 1'b1;
    nub_adn_i  = 32'hFFFF_FFFF;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) tick;

    check("rst_oe",    {nub_ad_oe, nub_tm_oe, nub_ack_oe}, 0);
    check("rst_ackn",  nub_ackn_o, 1);
    check("rst_tmn",   nub_tmn_o, 2'b11);
    check("rst_adn",   nub_adn_o, 32'hFFFF_FFFF);
    check("rst_mem",   {mem_valid, mem_wstrb, mem_myslot, mem_myexp}, 0);
    check("rst_addr",  mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    mem_reset = 1'b0;
    tick;

    // tm = {TM1,TM0}: 10 write, 11 write byte, 00 read
    xfer("wr_word", 32'hF000_0000, 2'b10, 32'h8765_4321, 32'h0,          32'hF000_0000, 4'b1111, 2);
    xfer("rd_word", 32'hF000_0000, 2'b00, 32'h0,          32'h8765_4321, 32'hF000_0000, 4'b0000, 1);
    xfer("wr_byte2",32'hF000_0016, 2'b11, 32'h00AB_0000, 32'h0,          32'hF000_0014, 4'b0100, 0);
    xfer("wr_byte0",32'hF000_0040, 2'b11, 32'h0000_005A, 32'h0,          32'hF000_0040, 4'b0001, 0);
    xfer("wr_half1",32'hF000_000B, 2'b10, 32'hBEEF_0000, 32'h0,          32'hF000_0008, 4'b1100, 3);
    xfer("wr_half0",32'hF000_0022, 2'b10, 32'h0000_1234, 32'h0,          32'hF000_0020, 4'b0011, 0);
    xfer("wr_block",32'hF000_0031, 2'b10, 32'hCAFE_F00D, 32'h0,          32'hF000_0030, 4'b1111, 1);

    // Address outside slot space, plus a stray mem_ready while idle.
    start_cycle(32'hEF00_0000, 2'b10, 32'h1111_2222);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 1);
      if (mem_valid || nub_ack_oe || nub_tm_oe || nub_ad_oe) seen = 1'b1;
      tick;
    end
    mem_ready = 1'b0;
    check("miss_quiet", seen, 0);

    // Slot ID 3: its own space hits, slot 0 space no longer does.
    nub_idn = 4'hC;
    tick;
    xfer("id3_rd", 32'hF300_0100, 2'b00, 32'h0, 32'h1357_9BDF, 32'hF300_0100, 4'b0000, 1);
    start_cycle(32'hF000_0000, 2'b00, 32'h0);
    check("id3_miss", mem_valid, 0);
    nub_idn = 4'hF;
    repeat (2) tick;

    // Timeout: mem_ready never comes.
    start_cycle(32'hF000_0050, 2'b00, 32'h0);
    check("to_valid", mem_valid, 1);
    k = 0;
    while (!nub_ack_oe && k < 400) begin
      tick;
      k++;
    end
    check("to_cycles", k, 200);
    check("to_status", {nub_ack_oe, nub_ackn_o, nub_tmn_o}, {1'b1, 1'b0, 2'b10});
    check("to_vdrop",  mem_valid, 0);
    tick;
    check("to_ackend", nub_ack_oe, 0);
    xfer("after_to", 32'hF000_0060, 2'b10, 32'h0BAD_BEEF, 32'h0, 32'hF000_0060, 4'b1111, 0);

    // Reset while the memory request is outstanding.
    start_cycle(32'hF000_0070, 2'b10, 32'h5555_AAAA);
    tick;
    mem_reset = 1'b1;
    tick;
    mem_reset = 1'b0;
    check("rstmid_valid", mem_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0);
      if (nub_ack_oe || !nub_ackn_o) seen = 1'b1;
      tick;
    end
    mem_ready = 1'b0;
    check("rstmid_noack", seen, 0);
    xfer("after_rst", 32'hF000_0080, 2'b00, 32'h0, 32'hA5A5_0F0F, 32'hF000_0080, 4'b0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
